// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter between the fetch and load/store clients for a single
// main memory, with read-latency timing and address bound checking.
module mem_access_arbiter #(
  parameter int AW     = 13,
  parameter int DW     = 13,
  parameter int DEPTH  = 13,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          err,
  output logic          busy,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_dataIn,
  output logic          mem_write,
  output logic          mem_read,
  output logic          mem_instruction,
  input  logic [DW-1:0] mem_dataOut
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP,
    S_ERR
  } state_t;

  state_t        r_state, w_stateNext;
  logic          r_lastD, w_lastD;
  logic          r_ownD, w_ownD;
  logic          r_we, w_we;
  logic [2:0]    r_cnt, w_cnt;

  logic          r_ifGnt, w_ifGnt;
  logic          r_dGnt, w_dGnt;
  logic          r_ifRvalid, w_ifRvalid;
  logic          r_dRvalid, w_dRvalid;
  logic [DW-1:0] r_ifRdata, w_ifRdata;
  logic [DW-1:0] r_dRdata, w_dRdata;
  logic          r_err, w_err;
  logic          r_busy, w_busy;
  logic [AW-1:0] r_memAddress, w_memAddress;
  logic [DW-1:0] r_memDataIn, w_memDataIn;
  logic          r_memWrite, w_memWrite;
  logic          r_memRead, w_memRead;
  logic          r_memInstr, w_memInstr;

  logic          w_pickD;
  logic [AW-1:0] w_selAddr;

  // On contention the data client wins unless it won the previous grant.
  assign w_pickD   = d_req & (~if_req | ~r_lastD);
  assign w_selAddr = w_pickD ? d_addr : if_addr;

  always_comb begin
    w_stateNext  = r_state;
    w_lastD      = r_lastD;
    w_ownD       = r_ownD;
    w_we         = r_we;
    w_cnt        = r_cnt;
    w_ifGnt      = 1'b0;
    w_dGnt       = 1'b0;
    w_ifRvalid   = 1'b0;
    w_dRvalid    = 1'b0;
    w_err        = 1'b0;
    w_memWrite   = 1'b0;
    w_memRead    = 1'b0;
    w_ifRdata    = r_ifRdata;
    w_dRdata     = r_dRdata;
    w_memAddress = r_memAddress;
    w_memDataIn  = r_memDataIn;
    w_memInstr   = r_memInstr;

    case (r_state)
      S_IDLE: begin
        if (if_req || d_req) begin
          w_ownD  = w_pickD;
          w_lastD = w_pickD;
          w_we    = w_pickD & d_we;
          w_ifGnt = ~w_pickD;
          w_dGnt  = w_pickD;
          // Out-of-range addresses never drive a strobe or the memory address.
          if (w_selAddr >= AW'(DEPTH)) begin
            w_stateNext = S_ERR;
            w_err       = 1'b1;
          end else begin
            w_stateNext  = S_ACCESS;
            w_memAddress = w_selAddr;
            w_memDataIn  = w_pickD ? d_wdata : '0;
            w_memInstr   = ~w_pickD;
            w_memWrite   = w_pickD & d_we;
            w_memRead    = ~(w_pickD & d_we);
          end
        end
      end

      S_ACCESS: begin
        if (r_we) begin
          w_stateNext = S_IDLE;
        end else begin
          w_stateNext = S_WAIT;
          w_cnt       = 3'd1;
        end
      end

      S_WAIT: begin
        if (r_cnt == 3'(RD_LAT)) begin
          w_stateNext = S_RESP;
          if (r_ownD) begin
            w_dRdata  = mem_dataOut;
            w_dRvalid = 1'b1;
          end else begin
            w_ifRdata  = mem_dataOut;
            w_ifRvalid = 1'b1;
          end
        end else begin
          w_cnt = r_cnt + 3'd1;
        end
      end

      S_RESP: begin
        w_stateNext = S_IDLE;
      end

      S_ERR: begin
        if (r_we) begin
          w_stateNext = S_IDLE;
        end else begin
          w_stateNext = S_RESP;
          if (r_ownD) begin
            w_dRdata  = '0;
            w_dRvalid = 1'b1;
          end else begin
            w_ifRdata  = '0;
            w_ifRvalid = 1'b1;
          end
        end
      end

      default: begin
        w_stateNext = S_IDLE;
      end
    endcase

    w_busy = (w_stateNext != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_lastD      <= 1'b0;
      r_ownD       <= 1'b0;
      r_we         <= 1'b0;
      r_cnt        <= 3'd0;
      r_ifGnt      <= 1'b0;
      r_dGnt       <= 1'b0;
      r_ifRvalid   <= 1'b0;
      r_dRvalid    <= 1'b0;
      r_ifRdata    <= '0;
      r_dRdata     <= '0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      r_memAddress <= '0;
      r_memDataIn  <= '0;
      r_memWrite   <= 1'b0;
      r_memRead    <= 1'b0;
      r_memInstr   <= 1'b0;
    end else begin
      r_state      <= w_stateNext;
      r_lastD      <= w_lastD;
      r_ownD       <= w_ownD;
      r_we         <= w_we;
      r_cnt        <= w_cnt;
      r_ifGnt      <= w_ifGnt;
      r_dGnt       <= w_dGnt;
      r_ifRvalid   <= w_ifRvalid;
      r_dRvalid    <= w_dRvalid;
      r_ifRdata    <= w_ifRdata;
      r_dRdata     <= w_dRdata;
      r_err        <= w_err;
      r_busy       <= w_busy;
      r_memAddress <= w_memAddress;
      r_memDataIn  <= w_memDataIn;
      r_memWrite   <= w_memWrite;
      r_memRead    <= w_memRead;
      r_memInstr   <= w_memInstr;
    end
  end

  assign if_gnt          = r_ifGnt;
  assign if_rvalid       = r_ifRvalid;
  assign if_rdata        = r_ifRdata;
  assign d_gnt           = r_dGnt;
  assign d_rvalid        = r_dRvalid;
  assign d_rdata         = r_dRdata;
  assign err             = r_err;
  assign busy            = r_busy;
  assign mem_address     = r_memAddress;
  assign mem_dataIn      = r_memDataIn;
  assign mem_write       = r_memWrite;
  assign mem_read        = r_memRead;
  assign mem_instruction = r_memInstr;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a one-cycle-latency memory model.
module tb_mem_access_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [12:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [12:0] if_rdata;
  logic        d_req, d_we;
  logic [12:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [12:0] d_rdata;
  logic        err, busy;
  logic [12:0] mem_address, mem_dataIn;
  logic        mem_write, mem_read, mem_instruction;
  logic [12:0] mem_dataOut = 13'h0;

  int checks = 0;
  int failures = 0;

  logic [12:0] instArr [0:12] = '{13'h000, 13'h111, 13'h000, 13'h1F0, 13'h044, 13'h000, 13'h000,
                                  13'h000, 13'h000, 13'h000, 13'h000, 13'h000, 13'h0C0};
  logic [12:0] dataArr [0:12] = '{13'h000, 13'h000, 13'h055, 13'h000, 13'h000, 13'h000, 13'h000,
                                  13'h000, 13'h000, 13'h000, 13'h000, 13'h000, 13'h000};

  mem_access_arbiter #(.AW(13), .DW(13), .DEPTH(13), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .err(err), .busy(busy),
    .mem_address(mem_address), .mem_dataIn(mem_dataIn), .mem_write(mem_write),
    .mem_read(mem_read), .mem_instruction(mem_instruction), .mem_dataOut(mem_dataOut)
  );

  always #5 clk = ~clk;

  // Memory model: read data appears in the cycle after the mem_read cycle.
  always @(posedge clk) begin
    if (mem_write && !mem_instruction && mem_address < 13)
      dataArr[mem_address] <= mem_dataIn;
    if (mem_read)
      mem_dataOut <= (mem_address < 13) ? (mem_instruction ? instArr[mem_address] : dataArr[mem_address]) : 13'h0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ifReq, input logic [12:0] ifAddr, input logic dReq,
                               input logic dWe, input logic [12:0] dAddr, input logic [12:0] dWdata);
    if_req  = ifReq;
    if_addr = ifAddr;
    d_req   = dReq;
    d_we    = dWe;
    d_addr  = dAddr;
    d_wdata = dWdata;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, 13'h0, 1'b0, 1'b0, 13'h0, 13'h0);
    nextCycle();
    nextCycle();
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_if_gnt", if_gnt, 1'b0);
    checkOutput("rst_d_gnt", d_gnt, 1'b0);
    checkOutput("rst_rvalid", {if_rvalid, d_rvalid}, 2'b00);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_strobes", {mem_read, mem_write, mem_instruction}, 3'b000);
    checkOutput("rst_addr", mem_address, 13'h0);
    checkOutput("rst_rdata", {if_rdata, d_rdata}, 26'h0);
    reset = 1'b1;

    $display("[TB] store to address 5");
    applyStimulus(1'b0, 13'h0, 1'b1, 1'b1, 13'd5, 13'h0AB);
    nextCycle();
    checkOutput("st_d_gnt", d_gnt, 1'b1);
    checkOutput("st_if_gnt", if_gnt, 1'b0);
    checkOutput("st_mem_write", mem_write, 1'b1);
    checkOutput("st_mem_read", mem_read, 1'b0);
    checkOutput("st_mem_address", mem_address, 13'd5);
    checkOutput("st_mem_dataIn", mem_dataIn, 13'h0AB);
    checkOutput("st_mem_instr", mem_instruction, 1'b0);
    checkOutput("st_busy_c1", busy, 1'b1);
    applyStimulus(1'b0, 13'h0, 1'b0, 1'b0, 13'd5, 13'h0);
    nextCycle();
    checkOutput("st_busy_c2", busy, 1'b0);
    checkOutput("st_write_c2", mem_write, 1'b0);

    $display("[TB] load from address 5");
    applyStimulus(1'b0, 13'h0, 1'b1, 1'b0, 13'd5, 13'h0);
    nextCycle();
    checkOutput("ld_d_gnt", d_gnt, 1'b1);
    checkOutput("ld_read_c1", mem_read, 1'b1);
    applyStimulus(1'b0, 13'h0, 1'b0, 1'b0, 13'd5, 13'h0);
    nextCycle();
    checkOutput("ld_read_c2", mem_read, 1'b0);
    checkOutput("ld_rvalid_c2", d_rvalid, 1'b0);
    checkOutput("ld_busy_c2", busy, 1'b1);
    nextCycle();
    checkOutput("ld_rvalid_c3", d_rvalid, 1'b1);
    checkOutput("ld_rdata_c3", d_rdata, 13'h0AB);
    checkOutput("ld_if_rvalid_c3", if_rvalid, 1'b0);
    checkOutput("ld_read_c3", mem_read, 1'b0);
    nextCycle();
    checkOutput("ld_rvalid_c4", d_rvalid, 1'b0);
    checkOutput("ld_busy_c4", busy, 1'b0);

    $display("[TB] fetch from address 3");
    applyStimulus(1'b1, 13'd3, 1'b0, 1'b0, 13'h0, 13'h0);
    nextCycle();
    checkOutput("if_gnt_c1", if_gnt, 1'b1);
    checkOutput("if_instr_c1", mem_instruction, 1'b1);
    checkOutput("if_read_c1", mem_read, 1'b1);
    checkOutput("if_write_c1", mem_write, 1'b0);
    applyStimulus(1'b0, 13'd3, 1'b0, 1'b0, 13'h0, 13'h0);
    nextCycle();
    checkOutput("if_instr_c2", mem_instruction, 1'b1);
    checkOutput("if_addr_c2", mem_address, 13'd3);
    nextCycle();
    checkOutput("if_rvalid_c3", if_rvalid, 1'b1);
    checkOutput("if_rdata_c3", if_rdata, 13'h1F0);
    checkOutput("if_d_rvalid_c3", d_rvalid, 1'b0);
    checkOutput("if_d_rdata_hold", d_rdata, 13'h0AB);
    nextCycle();

    $display("[TB] continuous contention from reset");
    reset = 1'b0;
    nextCycle();
    reset = 1'b1;
    applyStimulus(1'b1, 13'd1, 1'b1, 1'b0, 13'd2, 13'h0);
    for (int c = 1; c <= 12; c++) begin
      nextCycle();
      checkOutput($sformatf("ct_d_gnt_c%0d", c), d_gnt, (c == 1 || c == 9));
      checkOutput($sformatf("ct_if_gnt_c%0d", c), if_gnt, (c == 5));
      checkOutput($sformatf("ct_read_c%0d", c), mem_read, (c % 4 == 1));
      if (c == 3 || c == 11) checkOutput($sformatf("ct_d_rdata_c%0d", c), {d_rvalid, d_rdata}, {1'b1, 13'h055});
      if (c == 7) checkOutput("ct_if_rdata_c7", {if_rvalid, if_rdata}, {1'b1, 13'h111});
    end
    applyStimulus(1'b0, 13'd1, 1'b0, 1'b0, 13'd2, 13'h0);
    nextCycle();
    checkOutput("ct_busy_end", busy, 1'b0);

    $display("[TB] out-of-range load and store");
    applyStimulus(1'b0, 13'h0, 1'b1, 1'b0, 13'd13, 13'h0);
    nextCycle();
    checkOutput("el_d_gnt", d_gnt, 1'b1);
    checkOutput("el_err", err, 1'b1);
    checkOutput("el_strobes_c1", {mem_read, mem_write}, 2'b00);
    applyStimulus(1'b0, 13'h0, 1'b0, 1'b0, 13'd13, 13'h0);
    nextCycle();
    checkOutput("el_rvalid", d_rvalid, 1'b1);
    checkOutput("el_rdata", d_rdata, 13'h0);
    checkOutput("el_err_c2", err, 1'b0);
    checkOutput("el_strobes_c2", {mem_read, mem_write}, 2'b00);
    nextCycle();
    checkOutput("el_busy_c3", busy, 1'b0);
    applyStimulus(1'b0, 13'h0, 1'b1, 1'b1, 13'd20, 13'h077);
    nextCycle();
    checkOutput("es_err", {d_gnt, err, mem_write}, 3'b110);
    applyStimulus(1'b0, 13'h0, 1'b0, 1'b0, 13'd20, 13'h0);
    nextCycle();
    checkOutput("es_done", {busy, d_rvalid, mem_write}, 3'b000);

    $display("[TB] fetch at last valid address");
    applyStimulus(1'b1, 13'd12, 1'b0, 1'b0, 13'h0, 13'h0);
    nextCycle();
    checkOutput("lb_gnt_err", {if_gnt, err, mem_read}, 3'b101);
    applyStimulus(1'b0, 13'd12, 1'b0, 1'b0, 13'h0, 13'h0);
    nextCycle();
    nextCycle();
    checkOutput("lb_rdata", {if_rvalid, if_rdata}, {1'b1, 13'h0C0});
    nextCycle();

    $display("[TB] reset during fetch wait");
    applyStimulus(1'b1, 13'd4, 1'b0, 1'b0, 13'h0, 13'h0);
    nextCycle();
    checkOutput("rw_gnt", if_gnt, 1'b1);
    applyStimulus(1'b0, 13'd4, 1'b0, 1'b0, 13'h0, 13'h0);
    nextCycle();
    checkOutput("rw_busy_wait", busy, 1'b1);
    reset = 1'b0;
    nextCycle();
    checkOutput("rw_busy", busy, 1'b0);
    checkOutput("rw_strobes", {mem_read, mem_write}, 2'b00);
    checkOutput("rw_rvalid", if_rvalid, 1'b0);
    checkOutput("rw_rdata", if_rdata, 13'h0);
    reset = 1'b1;
    nextCycle();
    checkOutput("rw_rvalid_after1", if_rvalid, 1'b0);
    nextCycle();
    checkOutput("rw_rvalid_after2", if_rvalid, 1'b0);
    applyStimulus(1'b1, 13'd3, 1'b0, 1'b0, 13'h0, 13'h0);
    nextCycle();
    checkOutput("rw_new_gnt", if_gnt, 1'b1);
    applyStimulus(1'b0, 13'd3, 1'b0, 1'b0, 13'h0, 13'h0);
    nextCycle();
    nextCycle();
    checkOutput("rw_new_rdata", {if_rvalid, if_rdata}, {1'b1, 13'h1F0});
    nextCycle();
    checkOutput("rw_new_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
